collision_scanner: RTL
======================

# collision_scanner

Parametrised, sequential successor to the combinational bird/obstacle collision check. On a `start` pulse (one per frame, from the frame timing logic), it snapshots the bird box and all obstacle boxes. It checks ceiling/floor, then scans the obstacles one per cycle. Each run ends with a one-cycle `done` pulse carrying the first hit found. A sticky `crashed` flag feeds the game-state FSM.

## Interface
- `NUM_OBS`, 3: number of obstacle slots (1..16).
- `X_WIDTH`, 10: x coordinate width.
- `Y_WIDTH`, 9: y coordinate width.
- `CEIL_Y`, 0: bird_y_min <= CEIL_Y is a ceiling hit.
- `FLOOR_Y`, 479: bird_y_max >= FLOOR_Y is a floor hit.
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a scan; sampled only in IDLE.
- `clear`  in  1  clears `crashed`.
- `bird_x_min`, `bird_x_max`  in  X_WIDTH each  bird box, inclusive.
- `bird_y_min`, `bird_y_max`  in  Y_WIDTH each  bird box, inclusive.
- `obs_valid`  in  NUM_OBS  per-slot enable; a disabled slot never hits.
- `obs_x_min`, `obs_x_max`  in  [NUM_OBS][X_WIDTH]  pipe column span, inclusive.
- `obs_top_y_max`  in  [NUM_OBS][Y_WIDTH]  lowest row of the top pipe.
- `obs_bottom_y_min`  in  [NUM_OBS][Y_WIDTH]  highest row of the bottom pipe.
- `busy`  out  1  high in BOUNDS, SCAN, DONE.
- `done`  out  1  one-cycle pulse; results valid on it.
- `collision`  out  1  result of the last completed scan.
- `hit_kind`  out  3  NONE=0, CEIL=1, FLOOR=2, TOP=3, BOTTOM=4.
- `hit_index`  out  $clog2(NUM_OBS)+1  obstacle slot of a TOP/BOTTOM hit, else 0.
- `crashed`  out  1  sticky; set on `done` when `collision`=1.

## Operation
- FSM states: IDLE, BOUNDS, SCAN, DONE.
- IDLE -> BOUNDS on `start`. In the same edge, register the bird box and all obstacle inputs into a snapshot. Input changes after that edge do not affect the run.
- BOUNDS: evaluate ceiling, then floor, against the snapshot. Record the first hit only.
- SCAN: index `i` runs 0..NUM_OBS-1, one slot per cycle.
  - Slot hit: `obs_valid[i]` and bird_x_max >= x_min and bird_x_min <= x_max and (bird_y_min <= top_y_max or bird_y_max >= bottom_y_min).
  - TOP is reported if the top condition holds; otherwise BOTTOM.
  - A hit is recorded only if nothing has been recorded yet.
  - SCAN -> DONE after i = NUM_OBS-1. The scan never exits early, so latency is fixed.
- Result priority: CEIL > FLOOR > lowest index; TOP > BOTTOM within a slot.
- DONE: `done`=1. Update `collision`, `hit_kind`, `hit_index` and hold them until the next DONE. Always -> IDLE.
- All comparisons are unsigned and inclusive. No arithmetic is performed, so there is no overflow. Boxes with min > max are not rejected; they are evaluated literally.
- `start` outside IDLE is ignored and not queued. `start` held high starts back-to-back runs, one per NUM_OBS+3 cycles.
- `crashed`: set on DONE with a hit; cleared by `clear`. If `clear` and a hit DONE coincide, the set wins.

## Timing
- `start` sampled at edge t; BOUNDS in cycle t+1; SCAN in cycles t+2..t+1+NUM_OBS; DONE (`done`=1) in cycle t+2+NUM_OBS.
- `start` is accepted again at edge t+3+NUM_OBS.
- All outputs are registered or decoded from state, with no input-to-output combinational path.
- Reset values: state IDLE; `busy`=0, `done`=0, `collision`=0, `hit_kind`=NONE, `hit_index`=0, `crashed`=0; snapshot cleared.
- Reset during BOUNDS, SCAN or DONE aborts the run: no `done` pulse, all outputs at reset values on the next cycle.
- Reset has priority over `start` and `clear`.

## Structure
- Package `collision_pkg` holds:
  - `hit_kind_t` (3-bit enum).
  - `scan_state_t` (2-bit enum).
  - Default screen constants: SCREEN_W=640, SCREEN_H=480.
- Sub-module `obstacle_hit`: combinational, one instance, fed the slot selected by `i` through a mux. Outputs `top_hit` and `bottom_hit`.
- Snapshot registers, index counter, first-hit latch and FSM live in the top module.

## Test plan
Configuration: NUM_OBS=3, CEIL_Y=0, FLOOR_Y=7, all `obs_valid`=1.
- Obstacles:
  - slot 0: x 8..9, top_y_max 2, bottom_y_min 5.
  - slot 1: x 13..14, top_y_max 3, bottom_y_min 5.
  - slot 2: x 18..19, top_y_max 1, bottom_y_min 4.

1. Bird x 0..1, y 1..2; `start` one cycle -> `busy` for 5 cycles, `done` exactly 5 cycles after `start`, `collision`=0, `hit_kind`=NONE, `crashed`=0.
2. Bird x 7..8, y 6..6 -> BOTTOM, index 0, `crashed`=1. Then pulse `clear` -> `crashed`=0; `collision` is still held at 1.
3. Bird x 13..14, y 1..2 -> TOP, index 1. Repeat with `obs_valid`=3'b101 -> NONE.
4. Bird x 8..9, y 0..1 -> CEIL (wins over slot 0 TOP). Bird x 18..19, y 6..7 -> FLOOR (wins over slot 2 BOTTOM).
5. Bird x 8..9, y 3..4 -> NONE (gap). Change the bird to y 6..7 one cycle after `start` -> still NONE (snapshot). Re-pulse `start` during SCAN -> ignored; exactly one `done`.
6. Assert `reset` in the second SCAN cycle -> no `done`, all outputs 0. Hold `start` high for 12 cycles -> `done` pulses at cycles 5 and 11.

Source files
------------

// File: rtl/collision_pkg.sv
// Shared types and screen constants for the sequential collision scanner.
package collision_pkg;

    // Default screen geometry; the floor limit defaults to the last visible row.
    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    // Kind of the first hit found by a scan.
    typedef enum logic [2:0] {
        HIT_NONE   = 3'd0,
        HIT_CEIL   = 3'd1,
        HIT_FLOOR  = 3'd2,
        HIT_TOP    = 3'd3,
        HIT_BOTTOM = 3'd4
    } hit_kind_t;

    // Scanner control states.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BOUNDS = 2'd1,
        S_SCAN   = 2'd2,
        S_DONE   = 2'd3
    } scan_state_t;

endpackage

// File: rtl/collision_scanner_obstacle_hit.sv
// Combinational overlap test of the bird box against one obstacle slot.
module obstacle_hit #(
    parameter int unsigned X_WIDTH = 10,
    parameter int unsigned Y_WIDTH = 9
) (
    input  logic               valid_i,
    input  logic [X_WIDTH-1:0] bird_x_min_i,
    input  logic [X_WIDTH-1:0] bird_x_max_i,
    input  logic [Y_WIDTH-1:0] bird_y_min_i,
    input  logic [Y_WIDTH-1:0] bird_y_max_i,
    input  logic [X_WIDTH-1:0] x_min_i,
    input  logic [X_WIDTH-1:0] x_max_i,
    input  logic [Y_WIDTH-1:0] top_y_max_i,
    input  logic [Y_WIDTH-1:0] bottom_y_min_i,
    output logic               top_hit_o,
    output logic               bottom_hit_o
);

    logic x_overlap;

    // Column overlap gates both pipe tests; a disabled slot never hits.
    always_comb begin
        x_overlap    = valid_i && (bird_x_max_i >= x_min_i) && (bird_x_min_i <= x_max_i);
        top_hit_o    = x_overlap && (bird_y_min_i <= top_y_max_i);
        bottom_hit_o = x_overlap && (bird_y_max_i >= bottom_y_min_i);
    end

endmodule

// File: rtl/collision_scanner.sv
// Sequential bird/obstacle collision scanner: snapshot on start, check
// ceiling/floor, then one obstacle slot per cycle, report first hit on done.
module collision_scanner
    import collision_pkg::*;
#(
    parameter int unsigned NUM_OBS = 3,
    parameter int unsigned X_WIDTH = 10,
    parameter int unsigned Y_WIDTH = 9,
    parameter int unsigned CEIL_Y  = 0,
    parameter int unsigned FLOOR_Y = SCREEN_H - 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              clear,
    input  logic [X_WIDTH-1:0]                bird_x_min,
    input  logic [X_WIDTH-1:0]                bird_x_max,
    input  logic [Y_WIDTH-1:0]                bird_y_min,
    input  logic [Y_WIDTH-1:0]                bird_y_max,
    input  logic [NUM_OBS-1:0]                obs_valid,
    input  logic [NUM_OBS-1:0][X_WIDTH-1:0]   obs_x_min,
    input  logic [NUM_OBS-1:0][X_WIDTH-1:0]   obs_x_max,
    input  logic [NUM_OBS-1:0][Y_WIDTH-1:0]   obs_top_y_max,
    input  logic [NUM_OBS-1:0][Y_WIDTH-1:0]   obs_bottom_y_min,
    output logic                              busy,
    output logic                              done,
    output logic                              collision,
    output logic [2:0]                        hit_kind,
    output logic [$clog2(NUM_OBS):0]          hit_index,
    output logic                              crashed
);

    localparam int unsigned        IDX_W     = $clog2(NUM_OBS) + 1;
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_OBS - 1);
    localparam logic [Y_WIDTH-1:0] CEIL_LIM  = Y_WIDTH'(CEIL_Y);
    localparam logic [Y_WIDTH-1:0] FLOOR_LIM = Y_WIDTH'(FLOOR_Y);

    scan_state_t                     state_q;

    // Snapshot of the frame's geometry, taken on the accepting start edge.
    logic [X_WIDTH-1:0]              bx_min_q;
    logic [X_WIDTH-1:0]              bx_max_q;
    logic [Y_WIDTH-1:0]              by_min_q;
    logic [Y_WIDTH-1:0]              by_max_q;
    logic [NUM_OBS-1:0]              ov_q;
    logic [NUM_OBS-1:0][X_WIDTH-1:0] ox_min_q;
    logic [NUM_OBS-1:0][X_WIDTH-1:0] ox_max_q;
    logic [NUM_OBS-1:0][Y_WIDTH-1:0] otop_q;
    logic [NUM_OBS-1:0][Y_WIDTH-1:0] obot_q;

    // Scan index and first-hit latch.
    logic [IDX_W-1:0]                idx_q;
    hit_kind_t                       rec_kind_q;
    logic [IDX_W-1:0]                rec_idx_q;

    // Registered outputs.
    logic                            busy_q;
    logic                            done_q;
    logic                            collision_q;
    hit_kind_t                       kind_q;
    logic [IDX_W-1:0]                index_q;
    logic                            crashed_q;

    // Selected slot and its evaluation.
    logic                            sel_valid;
    logic [X_WIDTH-1:0]              sel_x_min;
    logic [X_WIDTH-1:0]              sel_x_max;
    logic [Y_WIDTH-1:0]              sel_top;
    logic [Y_WIDTH-1:0]              sel_bot;
    logic                            top_hit;
    logic                            bottom_hit;
    hit_kind_t                       bound_kind;
    hit_kind_t                       slot_kind;
    hit_kind_t                       fin_kind_d;
    logic [IDX_W-1:0]                fin_idx_d;

    // Route the snapshot slot addressed by the scan index to the comparator.
    always_comb begin
        sel_valid = 1'b0;
        sel_x_min = '0;
        sel_x_max = '0;
        sel_top   = '0;
        sel_bot   = '0;
        for (int unsigned k = 0; k < NUM_OBS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                sel_valid = ov_q[k];
                sel_x_min = ox_min_q[k];
                sel_x_max = ox_max_q[k];
                sel_top   = otop_q[k];
                sel_bot   = obot_q[k];
            end
        end
    end

    obstacle_hit #(
        .X_WIDTH (X_WIDTH),
        .Y_WIDTH (Y_WIDTH)
    ) u_obstacle_hit (
        .valid_i        (sel_valid),
        .bird_x_min_i   (bx_min_q),
        .bird_x_max_i   (bx_max_q),
        .bird_y_min_i   (by_min_q),
        .bird_y_max_i   (by_max_q),
        .x_min_i        (sel_x_min),
        .x_max_i        (sel_x_max),
        .top_y_max_i    (sel_top),
        .bottom_y_min_i (sel_bot),
        .top_hit_o      (top_hit),
        .bottom_hit_o   (bottom_hit)
    );

    // Prioritise bound and slot hits, keeping any hit already latched.
    always_comb begin
        bound_kind = HIT_NONE;
        if (by_min_q <= CEIL_LIM) begin
            bound_kind = HIT_CEIL;
        end else if (by_max_q >= FLOOR_LIM) begin
            bound_kind = HIT_FLOOR;
        end

        slot_kind = HIT_NONE;
        if (top_hit) begin
            slot_kind = HIT_TOP;
        end else if (bottom_hit) begin
            slot_kind = HIT_BOTTOM;
        end

        fin_kind_d = rec_kind_q;
        fin_idx_d  = rec_idx_q;
        if ((rec_kind_q == HIT_NONE) && (slot_kind != HIT_NONE)) begin
            fin_kind_d = slot_kind;
            fin_idx_d  = idx_q;
        end
    end

    // Scan control, snapshot capture, first-hit latch and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bx_min_q    <= '0;
            bx_max_q    <= '0;
            by_min_q    <= '0;
            by_max_q    <= '0;
            ov_q        <= '0;
            ox_min_q    <= '0;
            ox_max_q    <= '0;
            otop_q      <= '0;
            obot_q      <= '0;
            idx_q       <= '0;
            rec_kind_q  <= HIT_NONE;
            rec_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            collision_q <= 1'b0;
            kind_q      <= HIT_NONE;
            index_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q    <= S_BOUNDS;
                        busy_q     <= 1'b1;
                        bx_min_q   <= bird_x_min;
                        bx_max_q   <= bird_x_max;
                        by_min_q   <= bird_y_min;
                        by_max_q   <= bird_y_max;
                        ov_q       <= obs_valid;
                        ox_min_q   <= obs_x_min;
                        ox_max_q   <= obs_x_max;
                        otop_q     <= obs_top_y_max;
                        obot_q     <= obs_bottom_y_min;
                        idx_q      <= '0;
                        rec_kind_q <= HIT_NONE;
                        rec_idx_q  <= '0;
                    end
                end
                S_BOUNDS: begin
                    rec_kind_q <= bound_kind;
                    idx_q      <= '0;
                    state_q    <= S_SCAN;
                end
                S_SCAN: begin
                    rec_kind_q <= fin_kind_d;
                    rec_idx_q  <= fin_idx_d;
                    if (idx_q == LAST_IDX) begin
                        // Results load on the edge entering DONE so they are valid with done.
                        state_q     <= S_DONE;
                        done_q      <= 1'b1;
                        collision_q <= (fin_kind_d != HIT_NONE);
                        kind_q      <= fin_kind_d;
                        index_q     <= fin_idx_d;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky crash flag: set when a hitting result is presented; set beats clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            crashed_q <= 1'b0;
        end else if (done_q && collision_q) begin
            crashed_q <= 1'b1;
        end else if (clear) begin
            crashed_q <= 1'b0;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign collision = collision_q;
    assign hit_kind  = kind_q;
    assign hit_index = index_q;
    assign crashed   = crashed_q;

endmodule
